display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares one seg7 BCD-to-segment decoder among NDIG common-cathode digits.
- Holds a frame-coherent shadow copy of the BCD digits and steps through them at a fixed dwell rate.
- Drives the shared decoder's BCD input and the one-hot digit-enable lines, inserting blanking dead time between digits.
- Accepts new display values via a Load/Ack handshake, applied only at frame boundaries (no tearing).
- Sits between the numeric datapath (counters, BCD converters) and the board display pins.

---
 rtl/display_scan_ctrl_pkg.sv | 11 +
 rtl/display_scan_ctrl_if.sv | 25 ++
 rtl/display_scan_ctrl_timer.sv | 47 ++++
 rtl/display_scan_ctrl.sv | 106 ++++++++++
 tb/tb_display_scan_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and defaults for the
// multiplexed display scan controller.
package display_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam int NDIG_DEF  = 3;
  localparam int DWELL_DEF = 50000;
  localparam int GAP_DEF   = 4;
endpackage

// File: rtl/display_scan_ctrl_if.sv
// Datapath-facing bundle of the scan
// controller: load handshake and pins.
interface display_scan_if #(
  parameter int NDIG = 3
);
  import display_pkg::*;

  logic [4*NDIG-1:0] Digits;
  logic              Load;
  logic              LZS;
  bcd_t              Bcd;
  logic [NDIG-1:0]   Enable;
  logic              Ack;
  logic              Frame;

  modport master (
    output Digits, Load, LZS,
    input  Bcd, Enable, Ack, Frame
  );

  modport slave (
    input  Digits, Load, LZS,
    output Bcd, Enable, Ack, Frame
  );
endinterface

// File: rtl/display_scan_ctrl_timer.sv
// Slot/digit timer; exports the upcoming
// slot and phase so outputs can be registered.
module scan_timer #(
  parameter int NDIG  = 3,
  parameter int DWELL = 8,
  parameter int GAP   = 2,
  parameter int CW    = $clog2(DWELL),
  parameter int IW    = (NDIG > 1) ? $clog2(NDIG) : 1
)(
  input  logic          Clock,
  input  logic          Resetn,
  output logic          frame_end,
  output logic [IW-1:0] nxt_idx,
  output logic          nxt_blank
);
  localparam logic [CW-1:0] CLAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic [IW-1:0] idx;
  logic          slot_end;

  assign slot_end  = (cnt == CLAST);
  assign frame_end = slot_end && (idx == ILAST);

  always_comb begin
    nxt_cnt = slot_end ? '0 : cnt + CW'(1);
    nxt_idx = idx;
    if (frame_end)
      nxt_idx = '0;
    else if (slot_end)
      nxt_idx = idx + IW'(1);
  end

  assign nxt_blank = (nxt_cnt < CW'(GAP));

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= nxt_cnt;
      idx <= nxt_idx;
    end
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed BCD display scanner with
// frame-coherent shadow and Load/Ack handshake.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int DWELL = DWELL_DEF,
  parameter int GAP   = GAP_DEF
)(
  input  logic          Clock,
  input  logic          Resetn,
  display_scan_if.slave bus
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int W  = 4 * NDIG;

  logic          frame_end;
  logic [IW-1:0] nxt_idx;
  logic          nxt_blank;

  logic [W-1:0]    staging;
  logic [W-1:0]    shadow;
  logic [W-1:0]    shadow_nxt;
  logic            pending;
  logic            apply;
  bcd_t            bcd_q;
  bcd_t            bcd_nxt;
  logic [NDIG-1:0] en_q;
  logic [NDIG-1:0] en_nxt;
  logic            ack_q;

  scan_timer #(
    .NDIG  (NDIG),
    .DWELL (DWELL),
    .GAP   (GAP)
  ) u_timer (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .frame_end (frame_end),
    .nxt_idx   (nxt_idx),
    .nxt_blank (nxt_blank)
  );

  function automatic bcd_t dig_at(
    input logic [W-1:0]  v,
    input logic [IW-1:0] i
  );
    bcd_t d;
    d = '0;
    for (int k = 0; k < NDIG; k++)
      if (int'(i) == k) d = v[4*k +: 4];
    return d;
  endfunction

  // Upper digits hide when they and everything above are zero.
  function automatic logic suppressed(
    input logic [W-1:0]  v,
    input logic [IW-1:0] i,
    input logic          lzs
  );
    logic hz;
    hz = 1'b1;
    for (int k = 0; k < NDIG; k++)
      if (k >= int'(i) && v[4*k +: 4] != 4'd0)
        hz = 1'b0;
    return (dig_at(v, i) > BCD_MAX) ||
           (lzs && i != '0 && hz);
  endfunction

  assign apply = frame_end && (pending || bus.Load);

  always_comb begin
    shadow_nxt = shadow;
    if (apply)
      shadow_nxt = bus.Load ? bus.Digits : staging;
    bcd_nxt = dig_at(shadow_nxt, nxt_idx);
    en_nxt  = '0;
    if (!nxt_blank && !suppressed(shadow_nxt, nxt_idx, bus.LZS))
      for (int k = 0; k < NDIG; k++)
        if (int'(nxt_idx) == k) en_nxt[k] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      bcd_q   <= '0;
      en_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      if (bus.Load)
        staging <= bus.Digits;
      shadow  <= shadow_nxt;
      pending <= !apply && (pending || bus.Load);
      bcd_q   <= bcd_nxt;
      en_q    <= en_nxt;
      ack_q   <= apply;
    end
  end

  assign bus.Bcd    = bcd_q;
  assign bus.Enable = en_q;
  assign bus.Ack    = ack_q;
  assign bus.Frame  = frame_end;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised and directed checks of the scan
// controller against a cycle-count reference model.
module tb_display_scan_ctrl;
  localparam int N = 3;
  localparam int D = 8;
  localparam int G = 2;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;

  display_scan_if #(.NDIG(N)) bus();

  display_scan_ctrl #(
    .NDIG  (N),
    .DWELL (D),
    .GAP   (G)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  int          t;
  logic [11:0] m_sh;
  logic [11:0] m_st;
  bit          m_pend;
  bit          m_ack;
  logic        lzs_want;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h",
               tag, t, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_en(
    input logic [11:0] sh,
    input int c,
    input int i,
    input logic lz
  );
    int d;
    bit hz;
    d  = int'((sh >> (4*i)) & 12'hF);
    hz = 1'b1;
    for (int k = i; k < N; k++)
      if (((sh >> (4*k)) & 12'hF) != 0) hz = 1'b0;
    if (c < G || d > 9 || (lz && i > 0 && hz))
      return 3'b000;
    return 3'(1 << i);
  endfunction

  function automatic logic [11:0] rnd_digits();
    logic [11:0] v;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0:       v[4*k +: 4] = 4'd0;
        1:       v[4*k +: 4] = 4'($urandom_range(0, 15));
        default: v[4*k +: 4] = 4'($urandom_range(0, 9));
      endcase
    end
    return v;
  endfunction

  task automatic cyc(
    input bit          rn,
    input bit          ld,
    input logic [11:0] dg
  );
    int c;
    int i;
    bit fr;
    bit ap;
    @(negedge Clock);
    c  = t % D;
    i  = (t / D) % N;
    fr = (c == D-1) && (i == N-1);
    chk("bcd", 32'(bus.Bcd), 32'((m_sh >> (4*i)) & 12'hF));
    chk("enable", 32'(bus.Enable),
        32'(exp_en(m_sh, c, i, bus.LZS)));
    chk("onehot0", 32'($onehot0(bus.Enable)), 32'd1);
    chk("frame", 32'(bus.Frame), 32'(fr));
    chk("ack", 32'(bus.Ack), 32'(m_ack));
    if (c == 0) bus.LZS = lzs_want;
    Resetn     = rn;
    bus.Load   = ld;
    bus.Digits = dg;
    @(posedge Clock);
    if (!rn) begin
      t = 0; m_sh = '0; m_st = '0;
      m_pend = 1'b0; m_ack = 1'b0;
    end else begin
      ap = fr && (m_pend || ld);
      if (ap) m_sh = ld ? dg : m_st;
      if (ld) m_st = dg;
      m_ack  = ap;
      m_pend = !ap && (m_pend || ld);
      t++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, rnd_digits());
  endtask

  task automatic idle_to(input int target);
    while (t < target) cyc(1'b1, 1'b0, rnd_digits());
  endtask

  bit ld;
  bit rn;

  initial begin
    bus.Load = 1'b0;
    bus.Digits = '0;
    bus.LZS = 1'b0;
    lzs_want = 1'b0;
    t = 0; m_sh = '0; m_st = '0;
    m_pend = 1'b0; m_ack = 1'b0;

    @(posedge Clock);
    cyc(1'b0, 1'b0, 12'h0);

    // basic scan and mid-frame load
    idle_to(5);
    cyc(1'b1, 1'b1, 12'h359);
    idle_to(60);

    // double load, then load on the frame edge
    cyc(1'b0, 1'b0, 12'h0);
    idle_to(3);
    cyc(1'b1, 1'b1, 12'h111);
    idle_to(10);
    cyc(1'b1, 1'b1, 12'h222);
    idle_to(47);
    cyc(1'b1, 1'b1, 12'h333);
    idle_to(72);

    // suppression cases
    lzs_want = 1'b1;
    cyc(1'b1, 1'b1, 12'h007); idle(60);
    cyc(1'b1, 1'b1, 12'h000); idle(60);
    cyc(1'b1, 1'b1, 12'h070); idle(60);
    cyc(1'b1, 1'b1, 12'hA3F); idle(60);

    // reset while a load is pending
    lzs_want = 1'b0;
    cyc(1'b0, 1'b0, 12'h0);
    idle_to(5);
    cyc(1'b1, 1'b1, 12'h456);
    idle_to(10);
    cyc(1'b0, 1'b0, 12'h0);
    idle(60);

    repeat (3000) begin
      rn = ($urandom_range(0, 499) != 0);
      ld = ($urandom_range(0, 29) == 0);
      if (t % (D*N) == D*N - 1 && $urandom_range(0, 1) == 1)
        ld = 1'b1;
      if ($urandom_range(0, 99) == 0)
        lzs_want = 1'($urandom_range(0, 1));
      cyc(rn, ld, rnd_digits());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
